load_store_unit: RTL

Initiator-side master for the byte-addressed, big-endian `data_memory` block. It accepts one load or store request at a time from the datapath and drives the memory's `address`/`read`/`write`/`write_data` pins. It performs byte/halfword extraction with sign or zero extension for loads, and read-modify-write for sub-word stores, because the memory only writes full 4-byte words. It sits between the CPU's MEM stage and `data_memory`, and reports alignment and range errors instead of issuing bad accesses.

---
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/load_store_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Bus bundle between the datapath, the load/store unit and data_memory.
// The master modport is the load/store unit: it takes requests from the
// datapath and drives the memory pins. The slave modport is the
// surrounding environment, which is the datapath plus the memory.
interface load_store_unit_if;
  // Request from the datapath
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Response to the datapath
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  // Memory pins
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_out;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_error, resp_rdata,
    output mem_address, mem_read, mem_write, mem_write_data,
    input  mem_out
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_error, resp_rdata,
    input  mem_address, mem_read, mem_write, mem_write_data,
    output mem_out
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit for the big-endian, word-write-only data_memory.
// It handles one request at a time. Loads of a byte or a halfword pick
// the addressed lane out of the word and extend it. Stores of a byte or
// a halfword read the word, merge in the new lanes, then write the word
// back. Misaligned, out-of-range and illegal-size requests are answered
// with an error, and no memory access is made for them.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Selects the addressed byte or half from a big-endian word and extends it.
  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'h00;
    h = 16'h0000;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    if (off[1] == 1'b0) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replaces only the addressed lanes of the word with right-justified store data.
  function automatic logic [31:0] store_merge(
    input logic [31:0] word,
    input logic [31:0] wdata,
    input logic [1:0]  size,
    input logic [1:0]  off
  );
    logic [31:0] r;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    r = {wdata[7:0], word[23:0]};
          2'd1:    r = {word[31:24], wdata[7:0], word[15:0]};
          2'd2:    r = {word[31:16], wdata[7:0], word[7:0]};
          2'd3:    r = {word[31:8], wdata[7:0]};
          default: r = word;
        endcase
      end
      SZ_HALF: begin
        if (off[1] == 1'b0) begin
          r = {wdata[15:0], word[15:0]};
        end else begin
          r = {word[31:16], wdata[15:0]};
        end
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic [32:0] size_bytes;
  logic [32:0] access_end;
  logic        req_bad;

  // Decides whether the incoming request must be refused with an error.
  always_comb begin
    size_bytes = 33'd0;
    case (bus.req_size)
      SZ_BYTE: size_bytes = 33'd1;
      SZ_HALF: size_bytes = 33'd2;
      SZ_WORD: size_bytes = 33'd4;
      default: size_bytes = 33'd0;
    endcase
    // Sum is one bit wider than the address so it cannot wrap.
    access_end = {1'b0, bus.req_addr} + size_bytes;
    req_bad = 1'b0;
    if (bus.req_size == 2'd3) begin
      req_bad = 1'b1;
    end else if ((bus.req_size == SZ_HALF) && (bus.req_addr[0] != 1'b0)) begin
      req_bad = 1'b1;
    end else if ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00)) begin
      req_bad = 1'b1;
    end else if (access_end > 33'(MEM_BYTES)) begin
      req_bad = 1'b1;
    end else begin
      req_bad = 1'b0;
    end
  end

  // Computes the next state, the latched request and the response.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          off_d   = bus.req_addr[1:0];
          wdata_d = bus.req_wdata;
          if (req_bad) begin
            // Memory pins are left untouched for refused requests.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'h0000_0000;
          end else begin
            mem_addr_d = {bus.req_addr[31:2], 2'b00};
            if (bus.req_write && (bus.req_size == SZ_WORD)) begin
              mem_wdata_d = bus.req_wdata;
              state_d     = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (write_q) begin
          mem_wdata_d = store_merge(bus.mem_out, wdata_q, size_q, off_q);
          state_d     = S_WRITE;
        end else begin
          resp_rdata_d = load_extract(bus.mem_out, size_q, off_q, uns_q);
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_WRITE: begin
        resp_rdata_d = 32'h0000_0000;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= 2'd0;
      wdata_q      <= 32'h0000_0000;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_read       = (state_q == S_READ);
  // Reset gates the write strobe at once, so a reset that arrives during
  // WRITE cannot commit a half-finished read-modify-write.
  assign bus.mem_write      = (state_q == S_WRITE) && !reset;
  assign bus.mem_write_data = mem_wdata_q;

endmodule
